// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: sweeps every input vector of a 1-output FUT, streams (idx, bit)
// beats over valid/ready and accumulates a ones count and LFSR signature.
module tt_sweep_ctrl #(
  parameter int N_IN = 10,
  parameter int SETTLE = 2,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [N_IN-1:0]   f_x,
  input  logic              f_y,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic [N_IN-1:0]   tt_idx,
  output logic              tt_bit,
  output logic [N_IN:0]     ones_cnt,
  output logic [SIG_W-1:0]  sig
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SET = CW'(SETTLE);
  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] f_x_q, f_x_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tt_bit_q, tt_bit_d, aborted_q, aborted_d;
  logic [N_IN:0] ones_q, ones_d;
  logic [SIG_W-1:0] sig_q, sig_d, sig_next;
  assign sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                  ^ {{(SIG_W-1){1'b0}}, tt_bit_q};
  always_comb begin
    state_d = state_q;
    f_x_d = f_x_q;
    cnt_d = cnt_q;
    tt_bit_d = tt_bit_q;
    aborted_d = aborted_q;
    ones_d = ones_q;
    sig_d = sig_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = DRIVE;
        f_x_d = '0;
        cnt_d = SET;
        ones_d = '0;
        sig_d = '0;
        aborted_d = 1'b0;
      end
      DRIVE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          tt_bit_d = f_y;
          state_d = EMIT;
        end
      end
      EMIT: if (tt_ready) begin
        ones_d = ones_q + {{N_IN{1'b0}}, tt_bit_q};
        sig_d = sig_next;
        if (&f_x_q) state_d = DONE;
        else begin
          f_x_d = f_x_q + 1'b1;
          cnt_d = SET;
          state_d = DRIVE;
        end
      end
      DONE: state_d = IDLE;
    endcase
    // abort overrides the transition but a coinciding handshake is still counted
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      aborted_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      f_x_q <= '0;
      cnt_q <= '0;
      tt_bit_q <= 1'b0;
      aborted_q <= 1'b0;
      ones_q <= '0;
      sig_q <= '0;
    end else begin
      state_q <= state_d;
      f_x_q <= f_x_d;
      cnt_q <= cnt_d;
      tt_bit_q <= tt_bit_d;
      aborted_q <= aborted_d;
      ones_q <= ones_d;
      sig_q <= sig_d;
    end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign tt_valid = state_q == EMIT;
  assign aborted = aborted_q;
  assign f_x = f_x_q;
  assign tt_idx = f_x_q;
  assign tt_bit = tt_bit_q;
  assign ones_cnt = ones_q;
  assign sig = sig_q;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: directed sweeps against a beat-level reference model of the
// truth-table stream, plus a SETTLE=1 instance for the short-latency variant.
module tb_tt_sweep_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, tt_ready = 1'b1;
  logic busy, done, aborted, tt_valid, tt_bit, f_y;
  logic [9:0] f_x, tt_idx;
  logic [10:0] ones_cnt;
  logic [15:0] sig;
  logic start1 = 1'b0, busy1, done1, aborted1, tt_valid1, tt_bit1, f_y1;
  logic [9:0] f_x1, tt_idx1;
  logic [10:0] ones1;
  logic [15:0] sig1;
  int mode = 0, rdy_mode = 0, tests = 0, fails = 0;
  int exp_idx = 0, m_ones = 0;
  logic [15:0] m_sig = '0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  function automatic logic pla(input logic [9:0] x);
    return (x[0] & x[3] & ~x[7]) | (~x[1] & x[5]) | (x[2] & x[9] & x[4]) | (~x[8] & x[6] & ~x[0]);
  endfunction
  function automatic logic fut(input int m, input logic [9:0] x);
    return m == 0 ? 1'b0 : m == 1 ? x[0] : pla(x);
  endfunction
  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
  endfunction
  function automatic logic [15:0] sig_sweep(input int m);
    logic [15:0] s = '0;
    for (int i = 0; i < 1024; i++) s = sig_step(s, fut(m, 10'(i)));
    return s;
  endfunction

  assign f_y = mode == 0 ? 1'b0 : mode == 1 ? f_x[0] : pla(f_x);
  assign f_y1 = mode == 0 ? 1'b0 : mode == 1 ? f_x1[0] : pla(f_x1);

  tt_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .f_x(f_x), .f_y(f_y), .tt_valid(tt_valid), .tt_ready(tt_ready),
    .tt_idx(tt_idx), .tt_bit(tt_bit), .ones_cnt(ones_cnt), .sig(sig)
  );
  tt_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .busy(busy1), .done(done1),
    .aborted(aborted1), .f_x(f_x1), .f_y(f_y1), .tt_valid(tt_valid1), .tt_ready(1'b1),
    .tt_idx(tt_idx1), .tt_bit(tt_bit1), .ones_cnt(ones1), .sig(sig1)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {27'b0, busy, done, aborted, tt_valid, tt_bit}, 0);
    chk({tag, "_fx"}, {12'b0, f_x, tt_idx}, 0);
    chk({tag, "_ones"}, 32'(ones_cnt), 0);
    chk({tag, "_sig"}, 32'(sig), 0);
  endtask

  always @(posedge clk) begin
    #1;
    tt_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // beat-level model: one expected index advancing only on accepted beats
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0; m_ones = 0; m_sig = '0; prev_done = 1'b0;
    end else begin
      chk("ones_cnt", 32'(ones_cnt), m_ones);
      chk("sig", 32'(sig), 32'(m_sig));
      if (tt_valid) begin
        chk("tt_idx", 32'(tt_idx), exp_idx);
        chk("tt_bit", 32'(tt_bit), 32'(fut(mode, 10'(exp_idx))));
        chk("f_x_eq_idx", 32'(f_x), 32'(tt_idx));
      end
      if (!busy) chk("valid_idle", 32'(tt_valid), 0);
      if (done) begin
        chk("done_full", exp_idx, 1024);
        chk("done_once", 32'(prev_done), 0);
      end
      prev_done = done;
      if (tt_valid && tt_ready) begin
        m_ones += int'(fut(mode, 10'(exp_idx)));
        m_sig = sig_step(m_sig, fut(mode, 10'(exp_idx)));
        exp_idx++;
      end
      if (!busy && start && !abort) begin
        exp_idx = 0; m_ones = 0; m_sig = '0;
      end
    end
  end

  task automatic run_sweep(input int m, input int r, input int exp_cyc, input int poke);
    int cyc = 0;
    logic got = 1'b0;
    mode = m; rdy_mode = r;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!got && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        start = cyc == poke;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 1);
    if (exp_cyc != 0) chk("done_cycle", cyc, exp_cyc);
    chk("final_sig", 32'(sig), 32'(sig_sweep(m)));
    rdy_mode = 0;
  endtask

  task automatic abort_at(input int m, input int idx);
    int k = 0;
    mode = m; rdy_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!(busy && !tt_valid && f_x == 10'(idx)) && k < 5000) begin @(negedge clk); k++; end
    rdy_mode = 2;
    while (!(tt_valid && tt_idx == 10'(idx)) && k < 5000) begin @(negedge clk); k++; end
    chk("abort_reach", 32'(k < 5000), 1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(tt_valid), 0);
    chk("abort_flag", 32'(aborted), 1);
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done), 0);
  endtask

  initial begin
    int k;
    #12 chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    // T1 constant zero
    run_sweep(0, 0, 3073, 0);
    chk("t1_ones", 32'(ones_cnt), 0);
    chk("t1_sig", 32'(sig), 0);
    chk("t1_aborted", 32'(aborted), 0);
    // T2 y = x[0]
    run_sweep(1, 0, 3073, 0);
    chk("t2_ones", 32'(ones_cnt), 512);
    // beats 0,1,0,1 give signature 0->0->1->2->5
    abort_at(1, 4);
    chk("pin_ones4", 32'(ones_cnt), 2);
    chk("pin_sig4", 32'(sig), 5);
    // T4 abort at idx 37
    abort_at(1, 37);
    chk("t4_ones", 32'(ones_cnt), 18);
    // T5 start+abort in IDLE ignored; start mid-sweep ignored
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_aborted", 32'(aborted), 1);
    run_sweep(1, 0, 3073, 100);
    chk("t5_aborted_clr", 32'(aborted), 0);
    chk("t5_ones", 32'(ones_cnt), 512);
    // T3 PLA with random backpressure
    run_sweep(2, 1, 0, 0);
    // T6 reset during DRIVE of idx 500
    mode = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!(busy && !tt_valid && f_x == 10'd500) && k < 5000) begin @(negedge clk); k++; end
    chk("t6_reach", 32'(k < 5000), 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_zero("t6_async");
    @(posedge clk); #1 rst_n = 1'b1;
    run_sweep(0, 0, 3073, 0);
    chk("t6_ones0", 32'(ones_cnt), 0);
    run_sweep(1, 0, 3073, 0);
    chk("t6_ones1", 32'(ones_cnt), 512);
    // SETTLE=1 instance
    mode = 1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!done1 && k < 20000);
    chk("s1_done_cycle", k, 2049);
    chk("s1_ones", 32'(ones1), 512);
    chk("s1_sig", 32'(sig1), 32'(sig_sweep(1)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
